// File: rtl/hub75_capture.sv
// hub75_capture: panel-side HUB75 receiver. Oversamples the HUB75 lines in the clk
// domain, rebuilds each shifted row in a shift buffer, and on every latch commits it
// to a line buffer that is streamed out as pixel write beats tagged with row and plane.
// Optional feature macro: HUB75_CAPTURE_OE_MEAS_EN builds the OE-low width meter.
module hub75_capture #(
  parameter int unsigned hpixel_p   = 64,
  parameter int unsigned vpixel_p   = 64,
  parameter int unsigned bpp_p      = 8,
  parameter int unsigned segments_p = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_en,
  input  logic                        i_hub_clk,
  input  logic                        i_hub_lat,
  input  logic                        i_hub_oe_n,
  input  logic [$clog2(vpixel_p)-1:0] i_hub_row,
  input  logic [3*segments_p-1:0]     i_hub_rgb,
  output logic                        o_wr_valid,
  input  logic                        i_wr_ready,
  output logic [$clog2(hpixel_p)-1:0] o_wr_col,
  output logic [$clog2(vpixel_p)-1:0] o_wr_row,
  output logic [$clog2(bpp_p)-1:0]    o_wr_plane,
  output logic [3*segments_p-1:0]     o_wr_data,
  output logic                        o_oe_valid,
  output logic [31:0]                 o_oe_width,
  output logic                        o_overrun,
  output logic                        o_col_err
);

  localparam int unsigned ColW     = $clog2(hpixel_p);
  localparam int unsigned RowW     = $clog2(vpixel_p);
  localparam int unsigned PlaneW   = $clog2(bpp_p);
  localparam int unsigned DataW    = 3 * segments_p;
  localparam int unsigned One      = 1;
  localparam int unsigned HpixLast = hpixel_p - 1;
  localparam int unsigned BppLast  = bpp_p - 1;

  localparam logic [ColW:0]     ColFull   = hpixel_p[ColW:0];
  localparam logic [ColW:0]     ColLast   = HpixLast[ColW:0];
  localparam logic [ColW:0]     ColOne    = One[ColW:0];
  localparam logic [PlaneW-1:0] PlaneLast = BppLast[PlaneW-1:0];
  localparam logic [PlaneW-1:0] PlaneOne  = One[PlaneW-1:0];

  typedef enum logic [0:0] {StIdle, StDrain} state_e;

  // [0] and [1] form the synchronizer, [2] is the edge-detect delay stage
  logic [2:0]       hclk_sync_q, lat_sync_q;
  logic [RowW-1:0]  row_s1_q, row_s2_q;
  logic [DataW-1:0] rgb_s1_q, rgb_s2_q;

  // Registered internal edges with the data that belongs to them
  logic             shift_q, latch_q;
  logic [DataW-1:0] rgb_e_q;
  logic [RowW-1:0]  row_e_q;

  // Column c of a buffer holds the pixel bits for column c
  logic [hpixel_p-1:0][DataW-1:0] sbuf_q, sbuf_nx, line_q;
  logic [ColW:0]                  shift_cnt_q, cnt_nx, col_idx_q;
  logic [RowW-1:0]                row_q;
  logic [PlaneW-1:0]              plane_q, line_plane_q;
  logic                           col_err_q, overrun_q;
  logic                           commit, accept;
  state_e                         state_q, state_d;

  // Synchronize the asynchronous HUB75 lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hclk_sync_q <= '0;
      lat_sync_q  <= '0;
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      rgb_s1_q    <= '0;
      rgb_s2_q    <= '0;
    end else begin
      hclk_sync_q <= {hclk_sync_q[1:0], i_hub_clk};
      lat_sync_q  <= {lat_sync_q[1:0], i_hub_lat};
      row_s1_q    <= i_hub_row;
      row_s2_q    <= row_s1_q;
      rgb_s1_q    <= i_hub_rgb;
      rgb_s2_q    <= rgb_s1_q;
    end
  end

  // Detect rising edges and capture RGB/row from the same synchronized stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 1'b0;
      latch_q <= 1'b0;
      rgb_e_q <= '0;
      row_e_q <= '0;
    end else begin
      shift_q <= hclk_sync_q[1] & ~hclk_sync_q[2];
      latch_q <= lat_sync_q[1] & ~lat_sync_q[2];
      rgb_e_q <= rgb_s2_q;
      row_e_q <= row_s2_q;
    end
  end

  // Shift result and column count as if this cycle's shift edge is applied first
  always_comb begin
    sbuf_nx = {sbuf_q[hpixel_p-2:0], rgb_e_q};
    cnt_nx  = shift_cnt_q;
    if (shift_q && (shift_cnt_q != ColFull)) begin
      cnt_nx = shift_cnt_q + ColOne;
    end
    commit = i_en && latch_q && (state_q == StIdle);
    accept = (state_q == StDrain) && i_wr_ready;
  end

  // Shift buffer, line commit, counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbuf_q       <= '0;
      line_q       <= '0;
      shift_cnt_q  <= '0;
      col_idx_q    <= '0;
      row_q        <= '0;
      plane_q      <= '0;
      line_plane_q <= '0;
      col_err_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (!i_en) begin
      shift_cnt_q <= '0;
      col_idx_q   <= '0;
      plane_q     <= '0;
      col_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (shift_q) begin
        sbuf_q <= sbuf_nx;
      end
      if (latch_q) begin
        shift_cnt_q <= '0;
        if (cnt_nx != ColFull) begin
          col_err_q <= 1'b1;
        end
        if (state_q == StDrain) begin
          overrun_q <= 1'b1;
        end
      end else begin
        shift_cnt_q <= cnt_nx;
      end
      if (commit) begin
        line_q       <= shift_q ? sbuf_nx : sbuf_q;
        row_q        <= row_e_q;
        line_plane_q <= plane_q;
        plane_q      <= (plane_q == PlaneLast) ? '0 : plane_q + PlaneOne;
        col_idx_q    <= '0;
      end else if (accept) begin
        col_idx_q <= (col_idx_q == ColLast) ? '0 : col_idx_q + ColOne;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a committed latch starts a drain, the last accepted beat ends it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (commit) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!i_en) begin
          state_d = StIdle;
        end else if (accept && (col_idx_q == ColLast)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: beat fields come straight from registers so they hold during a stall
  always_comb begin
    o_wr_valid = (state_q == StDrain);
    o_wr_col   = col_idx_q[ColW-1:0];
    o_wr_data  = line_q[col_idx_q[ColW-1:0]];
    o_wr_row   = row_q;
    o_wr_plane = line_plane_q;
    o_overrun  = overrun_q;
    o_col_err  = col_err_q;
  end

`ifdef HUB75_CAPTURE_OE_MEAS_EN
  logic [2:0]  oe_sync_q;
  logic [31:0] oe_cnt_q, oe_width_q;
  logic        oe_valid_q;
  logic        oe_rise;

  assign oe_rise = oe_sync_q[1] & ~oe_sync_q[2];

  // Synchronize OE_n; resets to the inactive level so reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_sync_q <= '1;
    end else begin
      oe_sync_q <= {oe_sync_q[1:0], i_hub_oe_n};
    end
  end

  // Count OE-low cycles (saturating) and publish the width on the OE_n rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_cnt_q   <= '0;
      oe_width_q <= '0;
      oe_valid_q <= 1'b0;
    end else if (!i_en) begin
      oe_cnt_q   <= '0;
      oe_valid_q <= 1'b0;
    end else begin
      oe_valid_q <= oe_rise;
      if (oe_rise) begin
        oe_width_q <= oe_cnt_q;
        oe_cnt_q   <= '0;
      end else if (!oe_sync_q[1] && (oe_cnt_q != '1)) begin
        oe_cnt_q <= oe_cnt_q + 32'd1;
      end
    end
  end

  assign o_oe_valid = oe_valid_q;
  assign o_oe_width = oe_width_q;
`else
  logic unused_oe_n;
  assign unused_oe_n = i_hub_oe_n;
  assign o_oe_valid  = 1'b0;
  assign o_oe_width  = '0;
`endif

endmodule
